// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer master: register map, control bits,
// FSM encoding and a packed Avalon command word.
package interval_timer_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO_POS   = 0;
    localparam int CTRL_CONT_POS  = 1;
    localparam int CTRL_START_POS = 2;
    localparam int CTRL_STOP_POS  = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_PL   = 4'd1,
        ST_WR_PH   = 4'd2,
        ST_WR_CTRL = 4'd3,
        ST_RUN     = 4'd4,
        ST_CLR_ST  = 4'd5,
        ST_WR_STOP = 4'd6,
        ST_SNAP_WR = 4'd7,
        ST_RD_L    = 4'd8,
        ST_RD_H    = 4'd9,
        ST_RD_DONE = 4'd10
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } avm_cmd_t;

    localparam avm_cmd_t AVM_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic avm_cmd_t avm_wr(input logic [2:0] addr, input logic [15:0] data);
        return '{cs: 1'b1, write_n: 1'b0, addr: addr, wdata: data};
    endfunction

    function automatic avm_cmd_t avm_rd(input logic [2:0] addr);
        return '{cs: 1'b1, write_n: 1'b1, addr: addr, wdata: 16'd0};
    endfunction

endpackage

// File: rtl/interval_timer_master_if.sv
// Private point-to-point Avalon-MM link between the timer master and the timer slave.
interface interval_timer_master_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/interval_timer_master.sv
// Avalon-MM master that programs, services and snapshots the 16-bit-register interval timer.
// Bus outputs are registered from the next state, so each access appears the cycle after its trigger.
module interval_timer_master
    import interval_timer_pkg::*;
#(
    parameter int CTRL_ITO_BIT   = CTRL_ITO_POS,
    parameter int CTRL_CONT_BIT  = CTRL_CONT_POS,
    parameter int CTRL_START_BIT = CTRL_START_POS,
    parameter int CTRL_STOP_BIT  = CTRL_STOP_POS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic [31:0]                    cfg_period,
    input  logic                           cfg_continuous,
    input  logic                           stop_req,
    input  logic                           snap_req,
    input  logic                           timer_irq,
    interval_timer_master_if.master        avm,
    output logic                           running,
    output logic                           busy,
    output logic                           tick,
    output logic [31:0]                    tick_count,
    output logic [31:0]                    snap_value,
    output logic                           snap_valid
);

    localparam logic [15:0] CTRL_ITO   = 16'd1 << CTRL_ITO_BIT;
    localparam logic [15:0] CTRL_CONT  = 16'd1 << CTRL_CONT_BIT;
    localparam logic [15:0] CTRL_START = 16'd1 << CTRL_START_BIT;
    localparam logic [15:0] CTRL_STOP  = 16'd1 << CTRL_STOP_BIT;

    state_e      state_q, state_d;
    avm_cmd_t    cmd_q, cmd_d;
    logic [31:0] period_q, period_d;
    logic        cont_q, cont_d;
    logic        stop_pend_q, stop_pend_d;
    logic        snap_pend_q, snap_pend_d;
    logic        running_q, running_d;
    logic        tick_q, tick_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] snap_lo_q;
    logic [31:0] snap_q;

    logic stop_any, snap_any, cfg_accept;

    assign stop_any = stop_pend_q | stop_req;
    assign snap_any = snap_pend_q | snap_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start)     state_d = ST_WR_PL;
                else if (snap_any) state_d = ST_SNAP_WR;
            end
            ST_WR_PL:   state_d = ST_WR_PH;
            ST_WR_PH:   state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = ST_RUN;
            ST_RUN: begin
                if (timer_irq)     state_d = ST_CLR_ST;
                else if (cfg_start) state_d = ST_WR_PL;
                else if (stop_any) state_d = ST_WR_STOP;
                else if (snap_any) state_d = ST_SNAP_WR;
            end
            ST_CLR_ST:  state_d = cont_q ? ST_RUN : ST_IDLE;
            ST_WR_STOP: state_d = ST_IDLE;
            ST_SNAP_WR: state_d = ST_RD_L;
            ST_RD_L:    state_d = ST_RD_H;
            ST_RD_H:    state_d = ST_RD_DONE;
            ST_RD_DONE: state_d = running_q ? ST_RUN : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // WR_PL is only reachable from IDLE or RUN, so entering it means cfg_start was accepted.
    assign cfg_accept = (state_d == ST_WR_PL) && (state_q != ST_WR_PL);

    always_comb begin
        period_d    = cfg_accept ? cfg_period : period_q;
        cont_d      = cfg_accept ? cfg_continuous : cont_q;
        // A stop is meaningless once the FSM is heading to IDLE (timer already halted).
        stop_pend_d = stop_any && (state_d != ST_WR_STOP) && (state_d != ST_IDLE);
        snap_pend_d = snap_any && (state_d != ST_SNAP_WR);
        running_d   = running_q;
        if (state_q == ST_WR_CTRL)                 running_d = 1'b1;
        if (state_q == ST_WR_STOP)                 running_d = 1'b0;
        if ((state_q == ST_CLR_ST) && !cont_q)     running_d = 1'b0;
        tick_d      = (state_d == ST_CLR_ST);
        tick_cnt_d  = tick_cnt_q + {31'd0, tick_d};

        cmd_d = AVM_IDLE;
        unique case (state_d)
            ST_WR_PL:   cmd_d = avm_wr(ADDR_PERIOD_L, period_d[15:0]);
            ST_WR_PH:   cmd_d = avm_wr(ADDR_PERIOD_H, period_d[31:16]);
            ST_WR_CTRL: cmd_d = avm_wr(ADDR_CONTROL,
                                       CTRL_ITO | CTRL_START | (cont_d ? CTRL_CONT : 16'd0));
            ST_CLR_ST:  cmd_d = avm_wr(ADDR_STATUS, 16'd0);
            ST_WR_STOP: cmd_d = avm_wr(ADDR_CONTROL, CTRL_STOP);
            ST_SNAP_WR: cmd_d = avm_wr(ADDR_SNAP_L, 16'd0);
            ST_RD_L:    cmd_d = avm_rd(ADDR_SNAP_L);
            ST_RD_H:    cmd_d = avm_rd(ADDR_SNAP_H);
            default:    cmd_d = AVM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q       <= AVM_IDLE;
            period_q    <= 32'd0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            snap_pend_q <= 1'b0;
            running_q   <= 1'b0;
            tick_q      <= 1'b0;
            tick_cnt_q  <= 32'd0;
            snap_lo_q   <= 16'd0;
            snap_q      <= 32'd0;
        end else begin
            cmd_q       <= cmd_d;
            period_q    <= period_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            snap_pend_q <= snap_pend_d;
            running_q   <= running_d;
            tick_q      <= tick_d;
            tick_cnt_q  <= tick_cnt_d;
            if (state_q == ST_RD_H)    snap_lo_q <= avm.avm_readdata;
            if (state_q == ST_RD_DONE) snap_q    <= {avm.avm_readdata, snap_lo_q};
        end
    end

    assign avm.avm_chipselect = cmd_q.cs;
    assign avm.avm_write_n    = cmd_q.write_n;
    assign avm.avm_address    = cmd_q.addr;
    assign avm.avm_writedata  = cmd_q.wdata;

    // The high half arrives in RD_DONE itself; bypass it so snap_valid and the value coincide.
    assign snap_valid = (state_q == ST_RD_DONE);
    assign snap_value = snap_valid ? {avm.avm_readdata, snap_lo_q} : snap_q;
    assign running    = running_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign tick       = tick_q;
    assign tick_count = tick_cnt_q;

endmodule

// File: tb/tb_interval_timer_master.sv
// Directed bench for interval_timer_master with a behavioural timer slave and a bus-access scoreboard.
module tb_interval_timer_master;
    import interval_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_continuous, stop_req, snap_req;
    logic [31:0] cfg_period;
    logic        timer_irq;
    logic        running, busy, tick, snap_valid;
    logic [31:0] tick_count, snap_value;

    interval_timer_master_if bus();

    interval_timer_master dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .timer_irq(timer_irq), .avm(bus), .running(running), .busy(busy), .tick(tick),
        .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mism = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural timer slave: a stop write wins over a timeout on the same edge.
    logic [31:0] s_period, s_count, s_snap;
    logic        s_run, s_cont, s_ito, s_to;
    logic [15:0] s_rdata;
    assign bus.avm_readdata = s_rdata;
    assign timer_irq = s_to & s_ito;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_period <= 0; s_count <= 0; s_snap <= 0; s_rdata <= 0;
            s_run <= 0; s_cont <= 0; s_ito <= 0; s_to <= 0;
        end else begin
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd1 && bus.avm_writedata[3])
                s_run <= 1'b0;
            else if (s_run) begin
                if (s_count == 0) begin
                    s_to <= 1'b1;
                    s_count <= s_period;
                    if (!s_cont) s_run <= 1'b0;
                end else s_count <= s_count - 1;
            end
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                case (bus.avm_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: if (bus.avm_writedata[2]) begin
                        s_run <= 1'b1; s_count <= s_period;
                        s_cont <= bus.avm_writedata[1]; s_ito <= bus.avm_writedata[0];
                    end
                    3'd2: s_period[15:0]  <= bus.avm_writedata;
                    3'd3: s_period[31:16] <= bus.avm_writedata;
                    3'd4: s_snap <= s_count;
                    default: ;
                endcase
            end
            if (bus.avm_chipselect && bus.avm_write_n)
                s_rdata <= (bus.avm_address == 3'd4) ? s_snap[15:0] :
                           (bus.avm_address == 3'd5) ? s_snap[31:16] : 16'd0;
        end
    end

    // Scoreboard of expected bus accesses: {is_write, addr, wdata}.
    logic [19:0] exp_q[$];
    task automatic push_w(input logic [2:0] a, input logic [15:0] d); exp_q.push_back({1'b1, a, d}); endtask
    task automatic push_r(input logic [2:0] a); exp_q.push_back({1'b0, a, 16'd0}); endtask
    task automatic push_prog(input logic [31:0] p, input logic cont);
        push_w(3'd2, p[15:0]); push_w(3'd3, p[31:16]); push_w(3'd1, cont ? 16'h0007 : 16'h0005);
    endtask

    always @(negedge clk) begin
        logic [19:0] got, e;
        if (!reset && bus.avm_chipselect) begin
            got = {~bus.avm_write_n, bus.avm_address, bus.avm_write_n ? 16'd0 : bus.avm_writedata};
            compared++;
            assert (exp_q.size() != 0) else begin
                mism++;
                $error("FAIL bus_unexpected observed=%h expected=none", got);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bus_access", {12'd0, got}, {12'd0, e});
            end
        end
    end

    int irq_rises = 0, snap_valid_cnt = 0;
    logic irq_prev = 1'b0;
    always @(posedge clk) begin
        irq_prev <= timer_irq;
        if (timer_irq && !irq_prev) irq_rises++;
        if (snap_valid) snap_valid_cnt++;
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic pulse_cfg(input logic [31:0] p, input logic cont);
        cfg_period = p; cfg_continuous = cont; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic do_stop();
        push_w(3'd1, 16'h0008);
        stop_req = 1'b1; step(); stop_req = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_running", running, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"}, bus.avm_chipselect, 0);
        check({tag, "_write_n"}, bus.avm_write_n, 1);
        check({tag, "_addr"}, bus.avm_address, 0);
        check({tag, "_wdata"}, bus.avm_writedata, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_tick_count"}, tick_count, 0);
        check({tag, "_snap_value"}, snap_value, 0);
        check({tag, "_snap_valid"}, snap_valid, 0);
    endtask

    initial begin
        logic found;
        int   base, sv_before;
        reset = 1'b1; cfg_start = 0; cfg_continuous = 0; stop_req = 0; snap_req = 0; cfg_period = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        step();

        // Continuous programming: three back-to-back writes, then running.
        push_prog(32'h0009_8967, 1'b1);
        pulse_cfg(32'h0009_8967, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prog_cs", bus.avm_chipselect, 1);
            check("prog_busy", busy, 1);
        end
        @(negedge clk);
        check("prog_running", running, 1);
        check("prog_busy_run", busy, 0);
        do_stop();

        // One-shot period 3: single tick then IDLE.
        push_prog(32'd3, 1'b0);
        push_w(3'd0, 16'h0000);
        pulse_cfg(32'd3, 1'b0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin @(negedge clk); found = tick; end
        check("oneshot_tick_seen", found, 1);
        check("oneshot_tick_count", tick_count, 1);
        @(negedge clk);
        check("oneshot_tick_pulse", tick, 0);
        check("oneshot_running", running, 0);
        check("oneshot_state", dut.state_q, ST_IDLE);
        repeat (10) @(negedge clk);
        check("oneshot_no_retick", tick_count, 1);

        // Continuous period 3: ten serviced timeouts, one status write each.
        base = irq_rises;
        push_prog(32'd3, 1'b1);
        for (int i = 0; i < 10; i++) push_w(3'd0, 16'h0000);
        pulse_cfg(32'd3, 1'b1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin @(negedge clk); found = (tick_count == 32'd11); end
        check("cont_ticks_reached", found, 1);
        do_stop();
        check("cont_tick_count", tick_count, 11);
        check("cont_irq_rises", irq_rises - base, 10);

        // Snapshot: counter is 0x0001_2345 when the snap write lands.
        push_prog(32'h0001_2346, 1'b1);
        push_w(3'd4, 16'h0000); push_r(3'd4); push_r(3'd5);
        pulse_cfg(32'h0001_2346, 1'b1);
        repeat (3) step();
        snap_req = 1'b1; step(); snap_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("snap_valid_c%0d", k), snap_valid, (k == 4));
            if (k >= 4) check($sformatf("snap_value_c%0d", k), snap_value, 32'h0001_2345);
        end
        check("snap_running", running, 1);
        do_stop();

        // irq + stop + snap together: status clear, stop, then snapshot.
        push_prog(32'd3, 1'b1);
        push_w(3'd0, 16'h0000); push_w(3'd1, 16'h0008);
        push_w(3'd4, 16'h0000); push_r(3'd4); push_r(3'd5);
        pulse_cfg(32'd3, 1'b1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin @(negedge clk); found = timer_irq; end
        check("combo_irq_seen", found, 1);
        stop_req = 1'b1; snap_req = 1'b1; step(); stop_req = 1'b0; snap_req = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin @(negedge clk); found = snap_valid; end
        check("combo_snap_seen", found, 1);
        check("combo_running", running, 0);
        check("combo_tick_count", tick_count, 12);
        @(negedge clk);
        check("combo_idle", busy, 0);

        // Reset in RD_L: chipselect drops at once, no snap_valid afterwards.
        push_w(3'd4, 16'h0000); push_r(3'd4);
        snap_req = 1'b1; step(); snap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rdl_cs", bus.avm_chipselect, 1);
        check("rdl_addr", bus.avm_address, 3'd4);
        #1 reset = 1'b1;
        #1 check("async_cs_drop", bus.avm_chipselect, 0);
        @(negedge clk);
        check_reset_vals("midreset");
        sv_before = snap_valid_cnt;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("no_snap_after_reset", snap_valid_cnt - sv_before, 0);
        check("post_reset_busy", busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
